// File: rtl/dmem_pkg.sv
// Shared types and constants for the sized, big-endian MEM-stage data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Power-up image: the word at every aligned address A holds A + INIT_OFFSET.
  localparam logic [31:0] INIT_OFFSET = 32'd4;

  function automatic logic [31:0] init_word(input logic [31:0] addr);
    return addr + INIT_OFFSET;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Size/alignment decode: error flag, big-endian byte-lane write enables/data and load extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [3:0]  lane_we,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  // Lane 0 (bit 3 / bits 31:24) is the byte at the request address itself.
  always_comb begin
    err        = 1'b0;
    lane_we    = 4'b0000;
    lane_wdata = '0;
    load_data  = '0;
    case (size)
      SZ_BYTE: begin
        lane_we    = 4'b1000;
        lane_wdata = {wdata[7:0], 24'h000000};
        load_data  = {{24{~is_unsigned & rword[31]}}, rword[31:24]};
      end
      SZ_HALF: begin
        err        = addr_lo[0];
        lane_we    = 4'b1100;
        lane_wdata = {wdata[15:0], 16'h0000};
        load_data  = {{16{~is_unsigned & rword[31]}}, rword[31:16]};
      end
      SZ_WORD: begin
        err        = (addr_lo != 2'b00);
        lane_we    = 4'b1111;
        lane_wdata = wdata;
        load_data  = rword;
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      lane_we   = 4'b0000;
      load_data = '0;
    end
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable big-endian data memory with lb/lh/lw/sb/sh/sw, alignment
// checking and a configurable number of wait states behind a valid/ready channel.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic [DEPTH*8-1:0] init_image();
    logic [DEPTH*8-1:0] img;
    logic [31:0]        w;
    img = '0;
    for (int a = 0; a < DEPTH; a += 4) begin
      w = init_word(32'(a));
      for (int i = 0; i < 4; i++) img[(a+i)*8 +: 8] = w[31-8*i -: 8];
    end
    return img;
  endfunction

  // Byte at address A lives in bits [A*8 +: 8]; contents survive rst.
  logic [DEPTH*8-1:0] mem = init_image();

  state_e      state;
  logic [3:0]  count;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  addr_t       lat_addr;
  logic [31:0] lat_wdata;

  logic        exec;
  logic        cur_write;
  logic [1:0]  cur_size;
  logic        cur_unsigned;
  addr_t       cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] rword;
  logic        lane_err;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W];

  assign req_ready = (state == IDLE);
  assign stall     = (state == WAIT) || (state == IDLE && req_valid && HAS_WAIT);

  // Without wait states the access runs straight off the request inputs.
  assign exec         = HAS_WAIT ? (state == WAIT && count == 4'd1) : (state == IDLE && req_valid);
  assign cur_write    = HAS_WAIT ? lat_write    : req_write;
  assign cur_size     = HAS_WAIT ? lat_size     : req_size;
  assign cur_unsigned = HAS_WAIT ? lat_unsigned : req_unsigned;
  assign cur_addr     = HAS_WAIT ? lat_addr     : req_addr[ADDR_W-1:0];
  assign cur_wdata    = HAS_WAIT ? lat_wdata    : req_wdata;

  always_comb begin
    rword = '0;
    for (int i = 0; i < 4; i++)
      rword[31-8*i -: 8] = mem[{cur_addr + addr_t'(i), 3'b000} +: 8];
  end

  dmem_lane_align u_align (
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .addr_lo     (cur_addr[1:0]),
    .wdata       (cur_wdata),
    .rword       (rword),
    .err         (lane_err),
    .lane_we     (lane_we),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst && exec && cur_write) begin
      for (int i = 0; i < 4; i++)
        if (lane_we[3-i]) mem[{cur_addr + addr_t'(i), 3'b000} +: 8] <= lane_wdata[31-8*i -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      lat_write    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      rsp_valid <= exec;
      if (exec) begin
        rsp_err   <= lane_err;
        rsp_rdata <= (cur_write || lane_err) ? 32'h0 : load_data;
      end
      case (state)
        IDLE: begin
          if (req_valid && HAS_WAIT) begin
            state        <= WAIT;
            count        <= 4'(WAIT_STATES);
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr[ADDR_W-1:0];
            lat_wdata    <= req_wdata;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
